cnn_window_gen: RTL and testbench

//  Producer side of the conv window interface. Turns a raster pixel stream into

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/cnn_shift_window.sv | 49 ++++
 rtl/cnn_window_gen.sv | 168 ++++++++++++++++
 tb/tb_cnn_window_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the conv window datapath.
package cnn_pkg;

  localparam int DATA_W      = 32;
  localparam int WINDOW_SIZE = 3;

  typedef logic [DATA_W-1:0]          data_t;
  typedef data_t [WINDOW_SIZE-1:0]    window_t;

  typedef enum logic [1:0] {
    PAD_L = 2'd0,
    PIX   = 2'd1,
    PAD_R = 2'd2
  } fsm_state_t;

  // Counter width for a given bound; never narrower than one bit.
  function automatic int cnt_w(input int bound);
    return (bound <= 1) ? 1 : $clog2(bound);
  endfunction

endpackage

// File: rtl/cnn_shift_window.sv
// W-deep element shift register with a saturating fill count. taps_next is the
// register image after the current shift, so the caller can capture it in-cycle.
module cnn_shift_window import cnn_pkg::*; #(
  parameter int W = WINDOW_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift_en,
  input  logic                      row_clr,
  input  logic [DATA_W-1:0]         din,
  output logic [W-1:0][DATA_W-1:0]  taps_next,
  output logic                      complete
);

  localparam int                FILL_W   = cnt_w(W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W);

  logic [W-1:0][DATA_W-1:0] taps_q;
  logic [FILL_W-1:0]        fill_q;
  logic [FILL_W-1:0]        fill_next;

  // Newest element enters at the top; index 0 always holds the oldest.
  always_comb begin
    taps_next = taps_q;
    fill_next = fill_q;
    if (shift_en) begin
      for (int i = 0; i < W - 1; i++) begin
        taps_next[i] = taps_q[i+1];
      end
      taps_next[W-1] = din;
      if (fill_q != FILL_MAX) begin
        fill_next = fill_q + 1'b1;
      end
    end
  end

  assign complete = shift_en && (fill_next == FILL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
      fill_q <= '0;
    end else begin
      taps_q <= taps_next;
      fill_q <= row_clr ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to sliding conv windows, with optional zero padding at
// row edges and a window stride. Row-bounded: no window ever spans two rows.
module cnn_window_gen #(
  parameter int WINDOW_SIZE = cnn_pkg::WINDOW_SIZE,
  parameter int ROW_LEN     = 8,
  parameter int NUM_ROWS    = 8,
  parameter int PAD         = 0,
  parameter int STRIDE      = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        pix_valid,
  input  logic [cnn_pkg::DATA_W-1:0]                  pix_data,
  output logic                                        pix_ready,
  output logic                                        window_valid,
  output logic [WINDOW_SIZE-1:0][cnn_pkg::DATA_W-1:0] window,
  input  logic                                        window_stall,
  output logic                                        frame_done,
  output cnn_pkg::fsm_state_t                         dbg_state
);
  import cnn_pkg::*;

  localparam int COL_W = cnt_w(ROW_LEN);
  localparam int ROW_W = cnt_w(NUM_ROWS);
  localparam int PAD_W = cnt_w(PAD);
  localparam int PH_W  = cnt_w(STRIDE);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'((PAD > 0) ? PAD - 1 : 0);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);

  fsm_state_t state_q, state_d;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [PAD_W-1:0] pad_q;
  logic [PH_W-1:0]  phase_q;
  logic             fd_pend_q;

  logic hold, transfer, elem_en, pad_last, row_end, frame_end, complete, emit;
  logic [DATA_W-1:0]                   elem_data;
  logic [WINDOW_SIZE-1:0][DATA_W-1:0]  taps_next;

  // Handshakes: a pixel moves when pix_valid & pix_ready; a window moves when
  // window_valid & ~window_stall. A stalled window freezes the whole pipe.
  assign hold      = window_valid & window_stall;
  assign transfer  = window_valid & ~window_stall;
  assign pad_last  = (pad_q == PAD_LAST);
  assign frame_end = row_end && (row_q == ROW_LAST);
  assign emit      = complete && (phase_q == '0);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAD_L;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAD_L: begin
        if (PAD == 0) begin
          state_d = PIX;
        end else if (elem_en && pad_last) begin
          state_d = PIX;
        end
      end
      PIX: begin
        if (elem_en && (col_q == COL_LAST)) begin
          state_d = (PAD == 0) ? PIX : PAD_R;
        end
      end
      PAD_R: begin
        if (elem_en && pad_last) begin
          state_d = PAD_L;
        end
      end
      default: state_d = PAD_L;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    elem_en   = 1'b0;
    elem_data = '0;
    row_end   = 1'b0;
    case (state_q)
      PAD_L: begin
        elem_en = (PAD != 0) && !hold;
      end
      PIX: begin
        pix_ready = !hold;
        elem_en   = pix_valid && !hold;
        elem_data = pix_data;
        row_end   = (PAD == 0) && elem_en && (col_q == COL_LAST);
      end
      PAD_R: begin
        elem_en = !hold;
        row_end = elem_en && pad_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      pad_q   <= '0;
      phase_q <= '0;
    end else begin
      if (elem_en && (state_q == PIX)) begin
        col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end
      if (elem_en && (state_q != PIX)) begin
        pad_q <= pad_last ? '0 : pad_q + 1'b1;
      end
      // Row start restarts stride alignment; it outranks the last completion.
      if (row_end) begin
        row_q   <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        phase_q <= '0;
      end else if (complete) begin
        phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window_valid <= 1'b0;
      window       <= '0;
      frame_done   <= 1'b0;
      fd_pend_q    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (emit) begin
        window       <= taps_next;
        window_valid <= 1'b1;
      end else if (transfer) begin
        window_valid <= 1'b0;
      end
      // When the frame's last element made a window, wait for it to leave.
      if (frame_end && emit) begin
        fd_pend_q <= 1'b1;
      end else if (frame_end) begin
        frame_done <= 1'b1;
      end else if (fd_pend_q && transfer) begin
        frame_done <= 1'b1;
        fd_pend_q  <= 1'b0;
      end
    end
  end

  cnn_shift_window #(.W(WINDOW_SIZE)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (elem_en),
    .row_clr   (row_end),
    .din       (elem_data),
    .taps_next (taps_next),
    .complete  (complete)
  );

endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: five instances cover stride, padding, multi-row
// framing, stall and mid-row reset; a scoreboard checks every window transfer.
module tb_cnn_window_gen;
  import cnn_pkg::*;

  localparam int N     = 5;
  localparam int WIN_B = $bits(window_t);
  localparam int ENT_W = 3 + 1 + WIN_B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid    [N];
  data_t      pix_data     [N];
  logic       pix_ready    [N];
  logic       window_valid [N];
  window_t    window       [N];
  logic       window_stall [N];
  logic       frame_done   [N];
  fsm_state_t dbg_state    [N];

  logic [ENT_W-1:0] exp_q[$];
  int               xfer_cyc_q[$];
  logic [ENT_W-1:0] ent;
  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int fd_due  [N];
  int fd_seen [N];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_window_gen #(.ROW_LEN(5), .STRIDE(1)) u_dut0 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid[0]), .pix_data(pix_data[0]),
    .pix_ready(pix_ready[0]), .window_valid(window_valid[0]), .window(window[0]),
    .window_stall(window_stall[0]), .frame_done(frame_done[0]), .dbg_state(dbg_state[0]));

  cnn_window_gen #(.ROW_LEN(5), .STRIDE(2)) u_dut1 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid[1]), .pix_data(pix_data[1]),
    .pix_ready(pix_ready[1]), .window_valid(window_valid[1]), .window(window[1]),
    .window_stall(window_stall[1]), .frame_done(frame_done[1]), .dbg_state(dbg_state[1]));

  cnn_window_gen #(.ROW_LEN(6), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid[2]), .pix_data(pix_data[2]),
    .pix_ready(pix_ready[2]), .window_valid(window_valid[2]), .window(window[2]),
    .window_stall(window_stall[2]), .frame_done(frame_done[2]), .dbg_state(dbg_state[2]));

  cnn_window_gen #(.ROW_LEN(5), .PAD(1)) u_dut3 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid[3]), .pix_data(pix_data[3]),
    .pix_ready(pix_ready[3]), .window_valid(window_valid[3]), .window(window[3]),
    .window_stall(window_stall[3]), .frame_done(frame_done[3]), .dbg_state(dbg_state[3]));

  cnn_window_gen #(.ROW_LEN(5), .NUM_ROWS(2)) u_dut4 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid[4]), .pix_data(pix_data[4]),
    .pix_ready(pix_ready[4]), .window_valid(window_valid[4]), .window(window[4]),
    .window_stall(window_stall[4]), .frame_done(frame_done[4]), .dbg_state(dbg_state[4]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ENT_W-1:0] ent_of(input int k, input int a, input int b,
                                               input int c, input bit fd);
    window_t w;
    w[0] = data_t'(a);
    w[1] = data_t'(b);
    w[2] = data_t'(c);
    return {3'(k), fd, w};
  endfunction

  // driver tasks
  task automatic push_win(input int k, input int a, input int b, input int c, input bit fd);
    exp_q.push_back(ent_of(k, a, b, c, fd));
  endtask

  task automatic send_pix(input int k, input int d);
    int waited = 0;
    pix_valid[k] = 1'b1;
    pix_data[k]  = data_t'(d);
    @(negedge clk);
    while (!pix_ready[k] && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!pix_ready[k]) begin
      tests_run++;
      tests_failed++;
      $display("FAIL pix_accept_timeout dut%0d data %0d", k, d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int k, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      send_pix(k, first + i);
    end
    pix_valid[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    xfer_cyc_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (window_valid[k] && !window_stall[k]) begin
          xfer_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL spare_window dut%0d: got %0h expected none", k, window[k]);
          end else begin
            ent = exp_q.pop_front();
            check($sformatf("window_dut%0d", k), {3'(k), window[k]},
                  {ent[ENT_W-1 -: 3], ent[WIN_B-1:0]});
            if (ent[WIN_B]) fd_due[k] = cyc + 1;
          end
        end
        if (window_valid[k] && window_stall[k]) begin
          check($sformatf("ready_in_hold_dut%0d", k), pix_ready[k], 0);
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL held_window dut%0d: got %0h expected none", k, window[k]);
          end else begin
            check($sformatf("held_window_dut%0d", k), {3'(k), window[k]},
                  {exp_q[0][ENT_W-1 -: 3], exp_q[0][WIN_B-1:0]});
          end
        end
        if (frame_done[k]) begin
          fd_seen[k]++;
          check($sformatf("frame_done_cycle_dut%0d", k), cyc, fd_due[k]);
        end
      end
    end
  end

  initial begin
    #100000;
    tests_run++;
    tests_failed++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      pix_valid[k]    = 1'b0;
      pix_data[k]     = '0;
      window_stall[k] = 1'b0;
      fd_due[k]       = -100;
      fd_seen[k]      = 0;
    end
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_window_valid", window_valid[0], 0);
    check("rst_window", window[0], 0);
    check("rst_frame_done", frame_done[0], 0);
    check("rst_pix_ready", pix_ready[0], 0);
    check("rst_state", dbg_state[0], PAD_L);

    // stride 1, no stall: three windows back to back
    push_win(0, 1, 2, 3, 0);
    push_win(0, 2, 3, 4, 0);
    push_win(0, 3, 4, 5, 0);
    stream(0, 1, 5);
    drain();
    check("stride1_window_span", (xfer_cyc_q.size() >= 3) ? xfer_cyc_q[2] - xfer_cyc_q[0] : -1, 2);

    // stall the first window for four cycles
    do_reset();
    window_stall[0] = 1'b1;
    push_win(0, 1, 2, 3, 0);
    push_win(0, 2, 3, 4, 0);
    push_win(0, 3, 4, 5, 0);
    fork
      stream(0, 1, 5);
      begin
        int n = 0;
        while (!window_valid[0] && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (4) @(posedge clk);
        #1;
        window_stall[0] = 1'b0;
      end
    join
    drain();

    // stride 2
    do_reset();
    push_win(1, 1, 2, 3, 0);
    push_win(1, 3, 4, 5, 0);
    stream(1, 1, 5);
    drain();

    // stride 2, row of 6: trailing element consumed, next row realigned
    do_reset();
    push_win(2, 1, 2, 3, 0);
    push_win(2, 3, 4, 5, 0);
    push_win(2, 7, 8, 9, 0);
    push_win(2, 9, 10, 11, 0);
    stream(2, 1, 12);
    drain();

    // pad 1
    do_reset();
    @(negedge clk);
    check("pad_l_ready", pix_ready[3], 0);
    push_win(3, 0, 1, 2, 0);
    push_win(3, 1, 2, 3, 0);
    push_win(3, 2, 3, 4, 0);
    push_win(3, 3, 4, 5, 0);
    push_win(3, 4, 5, 0, 0);
    stream(3, 1, 5);
    @(negedge clk);
    check("pad_r_ready", pix_ready[3], 0);
    @(negedge clk);
    check("pad_l2_ready", pix_ready[3], 0);
    @(negedge clk);
    check("pix_row2_ready", pix_ready[3], 1);
    drain();

    // two-row frame
    do_reset();
    push_win(4, 1, 2, 3, 0);
    push_win(4, 2, 3, 4, 0);
    push_win(4, 3, 4, 5, 0);
    push_win(4, 11, 12, 13, 0);
    push_win(4, 12, 13, 14, 0);
    push_win(4, 13, 14, 15, 1);
    stream(4, 1, 5);
    stream(4, 11, 5);
    drain();
    check("frame_done_count", fd_seen[4], 1);

    // reset mid-row
    do_reset();
    stream(0, 201, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrow_rst_valid", window_valid[0], 0);
    check("midrow_rst_state", dbg_state[0], PAD_L);
    push_win(0, 21, 22, 23, 0);
    stream(0, 21, 3);
    drain();

    check("stray_frame_done", fd_seen[0] + fd_seen[1] + fd_seen[2] + fd_seen[3], 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
